// File: rtl/subleq_loader_pkg.sv
// subleq_loader_pkg: shared word width and loader state encoding.
package subleq_loader_pkg;
    localparam int WORD_SIZE = 16;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE, S_ERROR} state_e;
endpackage

// File: rtl/subleq_loader.sv
// subleq_loader: copies an image from a request/ack source into memory while holding the cpu in reset.
module subleq_loader
    import subleq_loader_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 start,
    output logic                 src_req,
    input  logic                 src_ack,
    input  logic                 src_eof,
    input  logic [WORD_SIZE-1:0] src_data,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 mem_load,
    output logic                 mem_store,
    output logic [WORD_SIZE-1:0] mem_in,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [WORD_SIZE-1:0] word_count
);
    // one extra bit so MAX_WORDS == 2^WORD_SIZE is still reachable
    localparam int CW = WORD_SIZE + 1;
    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WORD_SIZE-1:0] mem_in_q, mem_in_d, mem_addr_q, mem_addr_d;
    logic                 src_req_q, mem_req_q, cpu_hold_q, done_q, error_q;
    logic                 fetch_ok, write_ok;
    assign fetch_ok = src_req_q && src_ack;
    assign write_ok = mem_req_q && mem_ack;
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mem_in_d   = mem_in_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d = S_FETCH;
                count_d = '0;
            end
            S_FETCH: if (fetch_ok) begin
                if (src_eof) state_d = S_DONE;
                else if (count_q == CW'(MAX_WORDS)) state_d = S_ERROR;
                else begin
                    state_d    = S_WRITE;
                    mem_in_d   = src_data;
                    mem_addr_d = WORD_SIZE'(BASE_ADDR) + count_q[WORD_SIZE-1:0];
                end
            end
            S_WRITE: if (write_ok) begin
                state_d = S_FETCH;
                count_d = count_q + CW'(1);
            end
            default: ;
        endcase
    end
    // a request only rises after a full cycle in its state, giving the idle gap between phases
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            mem_in_q   <= '0;
            mem_addr_q <= '0;
            src_req_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mem_in_q   <= mem_in_d;
            mem_addr_q <= mem_addr_d;
            src_req_q  <= (state_q == S_FETCH) && (state_d == S_FETCH);
            mem_req_q  <= (state_q == S_WRITE) && (state_d == S_WRITE);
            cpu_hold_q <= state_d != S_DONE;
            done_q     <= state_d == S_DONE;
            error_q    <= state_d == S_ERROR;
        end
    end
    assign src_req    = src_req_q;
    assign mem_req    = mem_req_q;
    assign mem_store  = mem_req_q;
    assign mem_load   = 1'b0;
    assign mem_in     = mem_in_q;
    assign mem_addr   = mem_addr_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = count_q[WORD_SIZE-1:0];
endmodule
